// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives two requesters turns on one single-port word memory.
// Each access takes one IDLE (arbitrate/latch) cycle and one ACCESS cycle; read data returns a cycle later.
module mem_arbiter #(
    parameter int DEPTH = 4096,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q;
    logic          gnt_q;      // 1 = B
    logic          last_q;     // 1 = B was granted last
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          in_range_q;
    logic [DW-1:0] a_rdata_q, b_rdata_q;
    logic          a_rvalid_q, b_rvalid_q;

    logic          win_b_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          we_d;
    logic          in_range_d;
    logic [DW-1:0] rdata_d;
    logic          access;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win_b_d    = b_req & (~a_req | ~last_q);
        addr_d     = win_b_d ? b_addr  : a_addr;
        wdata_d    = win_b_d ? b_wdata : a_wdata;
        we_d       = win_b_d ? b_we    : a_we;
        in_range_d = {1'b0, addr_d} < DEPTH_W;
        rdata_d    = in_range_q ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req | b_req) begin
                        gnt_q      <= win_b_d;
                        addr_q     <= addr_d;
                        wdata_q    <= wdata_d;
                        we_q       <= we_d;
                        in_range_q <= in_range_d;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_q <= IDLE;
                    last_q  <= gnt_q;
                    if (!we_q) begin
                        if (gnt_q) begin
                            b_rdata_q  <= rdata_d;
                            b_rvalid_q <= 1'b1;
                        end else begin
                            a_rdata_q  <= rdata_d;
                            a_rvalid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset overrides the access strobes combinationally so an interrupted write never lands.
    assign access    = (state_q == ACCESS) & ~reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = access & we_q & in_range_q;
    assign a_ack     = access & ~gnt_q;
    assign b_ack     = access & gnt_q;
    assign a_err     = a_ack & ~in_range_q;
    assign b_err     = b_ack & ~in_range_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
    localparam int DEPTH = 4096;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, a_err, a_rvalid, b_ack, b_err, b_rvalid, mem_we;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem  [0:DEPTH-1];
    logic [DW-1:0] refm [0:DEPTH-1];
    int we_cnt = 0;
    int nvec = 0;
    int nerr = 0;

    mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory aliases out-of-range addresses so the arbiter must gate them itself.
    assign mem_rdata = mem[mem_addr[11:0]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    endtask

    task automatic do_reset;
        reset = 1; idle_inputs();
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset;
        reset = 1; a_req = 1; b_req = 1;
        tick(); tick();
        nvec++;
        if ({a_ack, a_err, a_rvalid, b_ack, b_err, b_rvalid, mem_we} !== 7'b0) begin
            nerr++; $display("FAIL reset_strobes: got %b want 0000000", {a_ack, a_err, a_rvalid, b_ack, b_err, b_rvalid, mem_we});
        end
        nvec++;
        if (a_rdata !== 0 || b_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            nerr++; $display("FAIL reset_data: a_rdata=%h b_rdata=%h mem_addr=%h mem_wdata=%h want all 0", a_rdata, b_rdata, mem_addr, mem_wdata);
        end
        reset = 0; idle_inputs();
    endtask

    task automatic test_read;
        int w0;
        mem[5] = 32'h12345678;
        w0 = we_cnt;
        a_req = 1; a_addr = 16'h0005; a_we = 0;
        tick();
        nvec++;
        if ({a_ack, a_err, b_ack, a_rvalid} !== 4'b1000) begin
            nerr++; $display("FAIL read_ack: got ack/err/back/rv=%b want 1000", {a_ack, a_err, b_ack, a_rvalid});
        end
        a_req = 0; a_addr = 16'($urandom);
        tick();
        nvec++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h12345678 || a_ack !== 1'b0) begin
            nerr++; $display("FAIL read_data: rvalid=%b rdata=%h ack=%b want 1 12345678 0", a_rvalid, a_rdata, a_ack);
        end
        tick();
        nvec++;
        if (a_rvalid !== 1'b0 || we_cnt !== w0) begin
            nerr++; $display("FAIL read_after: rvalid=%b writes=%0d want 0 0", a_rvalid, we_cnt - w0);
        end
    endtask

    task automatic test_alternate;
        logic [1:0] exp;
        do_reset();
        a_req = 1; b_req = 1; a_addr = 16'($urandom_range(0, 63)); b_addr = 16'($urandom_range(0, 63));
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k % 4 == 1) ? 2'b10 : (k % 4 == 3) ? 2'b01 : 2'b00;
            nvec++;
            if ({a_ack, b_ack} !== exp) begin
                nerr++; $display("FAIL alternate_c%0d: got a/b ack=%b want %b", k, {a_ack, b_ack}, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = we_cnt;
        b_req = 1; b_addr = 16'h0100; b_we = 1; b_wdata = 32'hDEADBEEF;
        tick();
        nvec++;
        if (b_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 32'hDEADBEEF || b_err !== 1'b0) begin
            nerr++; $display("FAIL wr_cycle: b_ack=%b mem_we=%b addr=%h wdata=%h err=%b", b_ack, mem_we, mem_addr, mem_wdata, b_err);
        end
        b_req = 0; b_we = 0;
        tick();
        nvec++;
        if (mem_we !== 1'b0 || b_rvalid !== 1'b0) begin
            nerr++; $display("FAIL wr_after: mem_we=%b b_rvalid=%b want 0 0", mem_we, b_rvalid);
        end
        a_req = 1; a_addr = 16'h0100; a_we = 0;
        tick();
        nvec++;
        if (a_ack !== 1'b1 || mem_we !== 1'b0) begin
            nerr++; $display("FAIL rd_back_ack: a_ack=%b mem_we=%b want 1 0", a_ack, mem_we);
        end
        a_req = 0;
        tick();
        nvec++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_rvalid !== 1'b0 || we_cnt - w0 !== 1) begin
            nerr++; $display("FAIL rd_back: rv=%b rdata=%h b_rv=%b writes=%0d want 1 deadbeef 0 1", a_rvalid, a_rdata, b_rvalid, we_cnt - w0);
        end
    endtask

    task automatic test_out_of_range;
        mem[0] = 32'hA5A5A5A5;
        b_req = 1; b_addr = 16'h1000; b_we = 1; b_wdata = 32'h11111111;
        tick();
        nvec++;
        if ({b_ack, b_err, mem_we, a_ack, a_err} !== 5'b11000) begin
            nerr++; $display("FAIL oor_wr: b_ack/b_err/mem_we/a_ack/a_err=%b want 11000", {b_ack, b_err, mem_we, a_ack, a_err});
        end
        b_req = 0; b_we = 0;
        tick();
        nvec++;
        if (b_rvalid !== 1'b0 || mem[0] !== 32'hA5A5A5A5) begin
            nerr++; $display("FAIL oor_wr_after: b_rvalid=%b mem0=%h want 0 a5a5a5a5", b_rvalid, mem[0]);
        end
        b_req = 1; b_addr = 16'h1000;
        tick();
        nvec++;
        if ({b_ack, b_err} !== 2'b11) begin
            nerr++; $display("FAIL oor_rd_ack: b_ack/b_err=%b want 11", {b_ack, b_err});
        end
        b_req = 0;
        tick();
        nvec++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h0 || b_err !== 1'b0) begin
            nerr++; $display("FAIL oor_rd: b_rvalid=%b b_rdata=%h b_err=%b want 1 0 0", b_rvalid, b_rdata, b_err);
        end
    endtask

    task automatic test_reset_in_access;
        mem[32] = 32'h0BADF00D;
        a_req = 1; a_addr = 16'h0020; a_we = 1; a_wdata = 32'h77777777;
        tick();
        reset = 1;
        #1;
        nvec++;
        if ({mem_we, a_ack, a_err, b_ack} !== 4'b0) begin
            nerr++; $display("FAIL rst_access: mem_we/a_ack/a_err/b_ack=%b want 0000", {mem_we, a_ack, a_err, b_ack});
        end
        idle_inputs();
        tick();
        reset = 0;
        nvec++;
        if (a_rvalid !== 1'b0 || mem[32] !== 32'h0BADF00D) begin
            nerr++; $display("FAIL rst_after: a_rvalid=%b mem20=%h want 0 0badf00d", a_rvalid, mem[32]);
        end
        a_req = 1; b_req = 1; a_addr = 16'h0001; b_addr = 16'h0002;
        tick();
        nvec++;
        if ({a_ack, b_ack} !== 2'b10) begin
            nerr++; $display("FAIL rst_first_tie: a/b ack=%b want 10", {a_ack, b_ack});
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_round_robin;
        logic [1:0] exp [1:5];
        exp[1] = 2'b10; exp[2] = 2'b00; exp[3] = 2'b01; exp[4] = 2'b00; exp[5] = 2'b10;
        a_req = 1; a_addr = 16'h0003; a_we = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            nvec++;
            if ({a_ack, b_ack} !== exp[k]) begin
                nerr++; $display("FAIL rr_c%0d: a/b ack=%b want %b", k, {a_ack, b_ack}, exp[k]);
            end
            if (k == 1) begin b_req = 1; b_addr = 16'h0004; b_we = 0; end
            if (k == 3) b_req = 0;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random;
        bit busy, last_b, gnt_b, acc, inr, rd_a, rd_b, g_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wdata, exp_ard, exp_brd;
        logic [6:0] got, expv;
        int await_a, await_b;
        do_reset();
        for (int i = 0; i < DEPTH; i++) refm[i] = mem[i];
        busy = 0; last_b = 1; rd_a = 0; rd_b = 0; exp_ard = '0; exp_brd = '0;
        await_a = 0; await_b = 0;
        for (int c = 0; c < 600; c++) begin
            acc = !busy && (a_req || b_req);
            gnt_b = b_req && (!a_req || !last_b);
            g_addr = gnt_b ? b_addr : a_addr;
            g_we = gnt_b ? b_we : a_we;
            g_wdata = gnt_b ? b_wdata : a_wdata;
            inr = int'(g_addr) < DEPTH;
            if (a_req) await_a++;
            if (b_req) await_b++;
            tick();
            got = {a_ack, a_err, b_ack, b_err, mem_we, a_rvalid, b_rvalid};
            expv = {acc && !gnt_b, acc && !gnt_b && !inr, acc && gnt_b, acc && gnt_b && !inr, acc && g_we && inr, rd_a, rd_b};
            nvec++;
            if (got !== expv) begin
                nerr++; $display("FAIL rnd_strobes c%0d: got %b want %b", c, got, expv);
            end
            nvec++;
            if (a_rdata !== exp_ard || b_rdata !== exp_brd) begin
                nerr++; $display("FAIL rnd_rdata c%0d: a=%h b=%h want %h %h", c, a_rdata, b_rdata, exp_ard, exp_brd);
            end
            rd_a = 0; rd_b = 0;
            if (acc) begin
                nvec++;
                if (mem_addr !== g_addr || (g_we && mem_wdata !== g_wdata) || (gnt_b ? await_b : await_a) > 4) begin
                    nerr++; $display("FAIL rnd_access c%0d: addr=%h want %h wait=%0d", c, mem_addr, g_addr, gnt_b ? await_b : await_a);
                end
                last_b = gnt_b;
                if (g_we && inr) refm[g_addr[11:0]] = g_wdata;
                if (!g_we) begin
                    if (gnt_b) begin rd_b = 1; exp_brd = inr ? refm[g_addr[11:0]] : '0; end
                    else begin rd_a = 1; exp_ard = inr ? refm[g_addr[11:0]] : '0; end
                end
            end
            busy = acc;
            if ((acc && !gnt_b) || !a_req) begin
                a_req = 1'($urandom % 2); a_we = 1'($urandom % 4 == 0); a_wdata = $urandom;
                a_addr = ($urandom % 5 == 0) ? 16'($urandom_range(DEPTH, 65535)) : 16'($urandom_range(0, 31));
                await_a = 0;
            end
            if ((acc && gnt_b) || !b_req) begin
                b_req = 1'($urandom % 2); b_we = 1'($urandom % 2); b_wdata = $urandom;
                b_addr = ($urandom % 5 == 0) ? 16'($urandom_range(DEPTH, 65535)) : 16'($urandom_range(0, 31));
                await_b = 0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        test_reset();
        test_read();
        test_alternate();
        test_back_to_back();
        test_out_of_range();
        test_reset_in_access();
        test_round_robin();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
